// File: rtl/count_game_ctrl.sv
// Round sequencer for the countdown reaction game: latches the start number,
// drives the countdown counter's load/start and display enable, judges the stop reaction, keeps score.
module count_game_ctrl #(
  parameter int unsigned WIN_WINDOW  = 300,
  parameter int unsigned RESULT_HOLD = 2000,
  parameter int unsigned NUM_MIN     = 3,
  parameter int unsigned NUM_MAX     = 7,
  parameter int unsigned TMR_W       = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic [2:0] sel_num,
  input  logic       over,
  output logic       cst,
  output logic       dzst,
  output logic [2:0] num,
  output logic       win,
  output logic       lose,
  output logic [3:0] score,
  output logic [2:0] state
);

  localparam int unsigned NUM_W   = 3;
  localparam int unsigned SCORE_W = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RUN    = 3'd2,
    WINDOW = 3'd3,
    RESULT = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [NUM_W-1:0]   num_q, num_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               win_q, win_d;
  logic               lose_q, lose_d;
  logic               cst_q, cst_d;
  logic               dzst_q, dzst_d;
  logic               start_prev_q, start_prev_d;
  logic               stop_prev_q, stop_prev_d;

  logic               start_press_c;
  logic               stop_press_c;
  logic               num_ok_c;
  logic [SCORE_W-1:0] score_inc_c;

  // Single-cycle press pulses; history resets high so a held button never fires.
  assign start_press_c = start_btn & ~start_prev_q;
  assign stop_press_c  = stop_btn & ~stop_prev_q;
  assign num_ok_c      = (sel_num >= NUM_W'(NUM_MIN)) && (sel_num <= NUM_W'(NUM_MAX));
  assign score_inc_c   = (score_q == {SCORE_W{1'b1}}) ? score_q : score_q + SCORE_W'(1);

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    num_d        = num_q;
    score_d      = score_q;
    win_d        = win_q;
    lose_d       = lose_q;
    start_prev_d = start_btn;
    stop_prev_d  = stop_btn;

    case (state_q)
      IDLE: begin
        win_d  = 1'b0;
        lose_d = 1'b0;
        if (start_press_c && num_ok_c) begin
          num_d   = sel_num;
          state_d = LOAD;
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        if (over && stop_press_c) begin
          state_d = RESULT;
          timer_d = '0;
          win_d   = 1'b1;
          lose_d  = 1'b0;
          score_d = score_inc_c;
        end else if (over) begin
          state_d = WINDOW;
          timer_d = '0;
        end else if (stop_press_c) begin
          state_d = RESULT;
          timer_d = '0;
          win_d   = 1'b0;
          lose_d  = 1'b1;
        end
      end
      WINDOW: begin
        if (stop_press_c && (timer_q < TMR_W'(WIN_WINDOW))) begin
          state_d = RESULT;
          timer_d = '0;
          win_d   = 1'b1;
          lose_d  = 1'b0;
          score_d = score_inc_c;
        end else if (timer_q == TMR_W'(WIN_WINDOW - 1)) begin
          state_d = RESULT;
          timer_d = '0;
          win_d   = 1'b0;
          lose_d  = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      RESULT: begin
        if (timer_q == TMR_W'(RESULT_HOLD - 1)) begin
          state_d = IDLE;
          timer_d = '0;
          win_d   = 1'b0;
          lose_d  = 1'b0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
        win_d   = 1'b0;
        lose_d  = 1'b0;
      end
    endcase

    // Counter/display controls follow the state being entered so they register with it.
    cst_d  = (state_d == RUN) || (state_d == WINDOW);
    dzst_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      num_q        <= '0;
      score_q      <= '0;
      win_q        <= 1'b0;
      lose_q       <= 1'b0;
      cst_q        <= 1'b0;
      dzst_q       <= 1'b0;
      start_prev_q <= 1'b1;
      stop_prev_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      num_q        <= num_d;
      score_q      <= score_d;
      win_q        <= win_d;
      lose_q       <= lose_d;
      cst_q        <= cst_d;
      dzst_q       <= dzst_d;
      start_prev_q <= start_prev_d;
      stop_prev_q  <= stop_prev_d;
    end
  end

  assign cst   = cst_q;
  assign dzst  = dzst_q;
  assign num   = num_q;
  assign win   = win_q;
  assign lose  = lose_q;
  assign score = score_q;
  assign state = state_q;

endmodule

// File: tb/tb_count_game_ctrl.sv
// Directed bench for count_game_ctrl: expected outputs are queued per step and
// compared against the DUT one cycle later.
module tb_count_game_ctrl;

  localparam int unsigned WIN  = 300;
  localparam int unsigned HOLD = 2000;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_WINDOW = 3'd3;
  localparam logic [2:0] S_RESULT = 3'd4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_btn;
  logic       stop_btn;
  logic [2:0] sel_num;
  logic       over;
  logic       cst;
  logic       dzst;
  logic [2:0] num;
  logic       win;
  logic       lose;
  logic [3:0] score;
  logic [2:0] state;

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic       c;
    logic       d;
    logic [2:0] n;
    logic       w;
    logic       l;
    logic [3:0] s;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_score;

  count_game_ctrl #(
    .WIN_WINDOW (WIN),
    .RESULT_HOLD(HOLD),
    .NUM_MIN    (3),
    .NUM_MAX    (7),
    .TMR_W      (12)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start_btn(start_btn),
    .stop_btn (stop_btn),
    .sel_num  (sel_num),
    .over     (over),
    .cst      (cst),
    .dzst     (dzst),
    .num      (num),
    .win      (win),
    .lose     (lose),
    .score    (score),
    .state    (state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string tag, input string field, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s.%s: observed %0d expected %0d", tag, field, obs, expv);
    end
  endtask

  // Queue the expectation for the coming edge, advance, then pop and compare.
  task automatic step_chk(input string tag, input logic [2:0] st, input logic c, input logic d,
                          input logic [2:0] n, input logic w, input logic l, input logic [3:0] s);
    exp_t e;
    e.tag = tag; e.st = st; e.c = c; e.d = d; e.n = n; e.w = w; e.l = l; e.s = s;
    sb.push_back(e);
    step();
    e = sb.pop_front();
    cmp(e.tag, "state", 8'(state), 8'(e.st));
    cmp(e.tag, "cst",   8'(cst),   8'(e.c));
    cmp(e.tag, "dzst",  8'(dzst),  8'(e.d));
    cmp(e.tag, "num",   8'(num),   8'(e.n));
    cmp(e.tag, "win",   8'(win),   8'(e.w));
    cmp(e.tag, "lose",  8'(lose),  8'(e.l));
    cmp(e.tag, "score", 8'(score), 8'(e.s));
  endtask

  task automatic start_round(input string tag, input logic [2:0] n, input logic [3:0] s);
    sel_num   = n;
    start_btn = 1'b1;
    step_chk({tag, "_load"}, S_LOAD, 1'b0, 1'b1, n, 1'b0, 1'b0, s);
    start_btn = 1'b0;
    step_chk({tag, "_run"}, S_RUN, 1'b1, 1'b1, n, 1'b0, 1'b0, s);
  endtask

  // 'already' = edges spent in RESULT since the entry edge last checked.
  task automatic finish_result(input string tag, input logic [2:0] n, input logic w, input logic l,
                               input logic [3:0] s, input int already);
    repeat (HOLD - 2 - already) step();
    step_chk({tag, "_last"}, S_RESULT, 1'b0, 1'b1, n, w, l, s);
    step_chk({tag, "_idle"}, S_IDLE, 1'b0, 1'b0, n, 1'b0, 1'b0, s);
  endtask

  initial begin
    rst       = 1'b0;
    start_btn = 1'b1;
    stop_btn  = 1'b0;
    sel_num   = 3'd5;
    over      = 1'b0;
    step();
    step_chk("reset", S_IDLE, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0);

    // Start held through reset must not start a round.
    rst = 1'b1;
    repeat (3) step_chk("held_start", S_IDLE, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0);
    start_btn = 1'b0;
    step_chk("release", S_IDLE, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0);

    // Round 1: over then stop 10 cycles later -> win.
    sel_num   = 3'd5;
    start_btn = 1'b1;
    step_chk("r1_load", S_LOAD, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 4'd0);
    start_btn = 1'b0;
    sel_num   = 3'd2;
    step_chk("r1_run", S_RUN, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 4'd0);
    sel_num   = 3'd6;
    step_chk("r1_num_kept", S_RUN, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 4'd0);
    over = 1'b1;
    step_chk("r1_window", S_WINDOW, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 4'd0);
    repeat (9) step();
    stop_btn = 1'b1;
    step_chk("r1_win", S_RESULT, 1'b0, 1'b1, 3'd5, 1'b1, 1'b0, 4'd1);
    stop_btn = 1'b0;
    over     = 1'b0;
    finish_result("r1", 3'd5, 1'b1, 1'b0, 4'd1, 0);

    // Out-of-range starts and stray stop are ignored in IDLE.
    sel_num   = 3'd2;
    start_btn = 1'b1;
    step_chk("sel2", S_IDLE, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0, 4'd1);
    start_btn = 1'b0;
    step();
    sel_num   = 3'd0;
    start_btn = 1'b1;
    step_chk("sel0", S_IDLE, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0, 4'd1);
    start_btn = 1'b0;
    stop_btn  = 1'b1;
    step_chk("idle_stop", S_IDLE, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0, 4'd1);
    stop_btn  = 1'b0;
    step();

    // Round 2: start ignored in RUN, early stop -> lose.
    start_round("r2", 3'd3, 4'd1);
    start_btn = 1'b1;
    step_chk("r2_start_ign", S_RUN, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 4'd1);
    start_btn = 1'b0;
    stop_btn  = 1'b1;
    step_chk("r2_early", S_RESULT, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 4'd1);
    stop_btn  = 1'b0;
    finish_result("r2", 3'd3, 1'b0, 1'b1, 4'd1, 0);

    // Round 3: over and stop in the same cycle -> win.
    start_round("r3", 3'd6, 4'd1);
    over     = 1'b1;
    stop_btn = 1'b1;
    step_chk("r3_simul", S_RESULT, 1'b0, 1'b1, 3'd6, 1'b1, 1'b0, 4'd2);
    over     = 1'b0;
    stop_btn = 1'b0;
    finish_result("r3", 3'd6, 1'b1, 1'b0, 4'd2, 0);

    // Round 4: no stop -> lose exactly WIN cycles after over; stop in RESULT ignored.
    start_round("r4", 3'd7, 4'd2);
    over = 1'b1;
    step_chk("r4_window", S_WINDOW, 1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 4'd2);
    over = 1'b0;
    repeat (WIN - 2) step();
    step_chk("r4_win_last", S_WINDOW, 1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 4'd2);
    step_chk("r4_timeout", S_RESULT, 1'b0, 1'b1, 3'd7, 1'b0, 1'b1, 4'd2);
    stop_btn = 1'b1;
    step_chk("r4_stop_ign", S_RESULT, 1'b0, 1'b1, 3'd7, 1'b0, 1'b1, 4'd2);
    stop_btn = 1'b0;
    finish_result("r4", 3'd7, 1'b0, 1'b1, 4'd2, 1);

    // 14 more wins (16 total) -> score saturates at 15.
    exp_score = 2;
    for (int i = 0; i < 14; i++) begin
      start_round("sat", 3'd4, 4'(exp_score));
      exp_score = (exp_score < 15) ? exp_score + 1 : 15;
      over     = 1'b1;
      stop_btn = 1'b1;
      step_chk("sat_win", S_RESULT, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 4'(exp_score));
      over     = 1'b0;
      stop_btn = 1'b0;
      finish_result("sat", 3'd4, 1'b1, 1'b0, 4'(exp_score), 0);
    end
    cmp("sat_final", "score", 8'(score), 8'd15);

    // Reset mid-WINDOW clears everything including score.
    start_round("r5", 3'd5, 4'd15);
    over = 1'b1;
    step_chk("r5_window", S_WINDOW, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 4'd15);
    repeat (5) step();
    rst  = 1'b0;
    over = 1'b0;
    step_chk("rst_mid", S_IDLE, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0);
    rst = 1'b1;
    step_chk("post_rst", S_IDLE, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
